// File: rtl/id_ex_stage.sv
// ID/EX stage: single-entry operand select with RAW forwarding and load-use interlock; 1-cycle latency, zero-bubble.
// ID_EX_FWD_EN enables EX/MEM and MEM/WB forwarding; without it, hazards stall until the producer has written back.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CTL_W = 4,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [RA_W-1:0]  in_rs1_addr,
  input  logic [RA_W-1:0]  in_rs2_addr,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_use_pc,
  input  logic             in_use_imm,
  input  logic [CTL_W-1:0] in_ctl,
  input  logic [RA_W-1:0]  in_rd_addr,
  input  logic             in_rd_we,
  input  logic             in_is_load,
  input  logic [RA_W-1:0]  exm_rd_addr,
  input  logic             exm_rd_we,
  input  logic             exm_is_load,
  input  logic [XLEN-1:0]  exm_result,
  input  logic [RA_W-1:0]  mwb_rd_addr,
  input  logic             mwb_rd_we,
  input  logic [XLEN-1:0]  mwb_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_a,
  output logic [XLEN-1:0]  out_b,
  output logic [CTL_W-1:0] out_ctl,
  output logic [XLEN-1:0]  out_store_data,
  output logic [RA_W-1:0]  out_rd_addr,
  output logic             out_rd_we,
  output logic             out_is_load,
  output logic [XLEN-1:0]  out_pc
);

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [RA_W-1:0]  rs1_addr;
    logic [RA_W-1:0]  rs2_addr;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic             use_pc;
    logic             use_imm;
    logic [CTL_W-1:0] ctl;
    logic [RA_W-1:0]  rd_addr;
    logic             rd_we;
    logic             is_load;
  } entry_t;

  entry_t          ent_q, ent_d;
  logic            full_q, full_d;
  logic            in_fire, out_fire, hazard;
  logic            rs1_exm_hit, rs2_exm_hit, rs1_mwb_hit, rs2_mwb_hit;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  assign rs1_exm_hit = exm_rd_we && (ent_q.rs1_addr != '0) && (exm_rd_addr == ent_q.rs1_addr);
  assign rs2_exm_hit = exm_rd_we && (ent_q.rs2_addr != '0) && (exm_rd_addr == ent_q.rs2_addr);
  assign rs1_mwb_hit = mwb_rd_we && (ent_q.rs1_addr != '0) && (mwb_rd_addr == ent_q.rs1_addr);
  assign rs2_mwb_hit = mwb_rd_we && (ent_q.rs2_addr != '0) && (mwb_rd_addr == ent_q.rs2_addr);

`ifdef ID_EX_FWD_EN
  // EX/MEM wins over MEM/WB; a load in EX/MEM has no result yet and must interlock instead.
  always_comb begin
    rs1_fwd = ent_q.rs1_data;
    if (ent_q.rs1_addr == '0)            rs1_fwd = '0;
    else if (rs1_exm_hit && !exm_is_load) rs1_fwd = exm_result;
    else if (rs1_mwb_hit)                rs1_fwd = mwb_result;
  end

  always_comb begin
    rs2_fwd = ent_q.rs2_data;
    if (ent_q.rs2_addr == '0)            rs2_fwd = '0;
    else if (rs2_exm_hit && !exm_is_load) rs2_fwd = exm_result;
    else if (rs2_mwb_hit)                rs2_fwd = mwb_result;
  end

  // rs2 is always checked: stores need it even when b takes the immediate.
  assign hazard = full_q && exm_is_load && ((!ent_q.use_pc && rs1_exm_hit) || rs2_exm_hit);
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{exm_is_load, exm_result};

  assign rs1_fwd = ent_q.rs1_data;
  assign rs2_fwd = ent_q.rs2_data;
  assign hazard  = full_q && ((!ent_q.use_pc && (rs1_exm_hit || rs1_mwb_hit)) ||
                              rs2_exm_hit || rs2_mwb_hit);
`endif

  assign out_valid = full_q && !hazard;
  assign out_fire  = out_valid && out_ready;
  assign in_ready  = !full_q || out_fire;
  assign in_fire   = in_valid && in_ready;

  always_comb begin
    full_d = full_q;
    ent_d  = ent_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (in_fire) begin
      full_d         = 1'b1;
      ent_d.pc       = in_pc;
      ent_d.rs1_addr = in_rs1_addr;
      ent_d.rs2_addr = in_rs2_addr;
      ent_d.rs1_data = in_rs1_data;
      ent_d.rs2_data = in_rs2_data;
      ent_d.imm      = in_imm;
      ent_d.use_pc   = in_use_pc;
      ent_d.use_imm  = in_use_imm;
      ent_d.ctl      = in_ctl;
      ent_d.rd_addr  = in_rd_addr;
      ent_d.rd_we    = in_rd_we;
      ent_d.is_load  = in_is_load;
    end else if (out_fire) begin
      full_d = 1'b0;
    end else if (full_q) begin
      // Values retiring during a stall would otherwise be gone when the stall ends.
      if (rs1_mwb_hit) ent_d.rs1_data = mwb_result;
      if (rs2_mwb_hit) ent_d.rs2_data = mwb_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      ent_q  <= '0;
    end else begin
      full_q <= full_d;
      ent_q  <= ent_d;
    end
  end

  assign out_a          = ent_q.use_pc  ? ent_q.pc  : rs1_fwd;
  assign out_b          = ent_q.use_imm ? ent_q.imm : rs2_fwd;
  assign out_store_data = rs2_fwd;
  assign out_ctl        = ent_q.ctl;
  assign out_rd_addr    = ent_q.rd_addr;
  assign out_rd_we      = ent_q.rd_we;
  assign out_is_load    = ent_q.is_load;
  assign out_pc         = ent_q.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table, directed hazard/flush sequences, and randomized traffic against a model.
module tb_id_ex_stage;
  localparam int XLEN = 32, CTL_W = 4, RA_W = 5;
`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0, rst, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic        in_use_pc, in_use_imm, in_rd_we, in_is_load;
  logic [3:0]  in_ctl;
  logic [4:0]  exm_rd_addr, mwb_rd_addr;
  logic        exm_rd_we, exm_is_load, mwb_rd_we;
  logic [31:0] exm_result, mwb_result;
  logic        out_valid, out_ready, out_rd_we, out_is_load;
  logic [31:0] out_a, out_b, out_store_data, out_pc;
  logic [3:0]  out_ctl;
  logic [4:0]  out_rd_addr;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CTL_W(CTL_W), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_use_pc(in_use_pc), .in_use_imm(in_use_imm), .in_ctl(in_ctl),
    .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
    .exm_rd_addr(exm_rd_addr), .exm_rd_we(exm_rd_we), .exm_is_load(exm_is_load),
    .exm_result(exm_result), .mwb_rd_addr(mwb_rd_addr), .mwb_rd_we(mwb_rd_we),
    .mwb_result(mwb_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_ctl(out_ctl), .out_store_data(out_store_data),
    .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we), .out_is_load(out_is_load),
    .out_pc(out_pc)
  );

  int passed = 0, total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; in_pc = 0; in_rs1_addr = 0; in_rs2_addr = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_use_pc = 0; in_use_imm = 0;
    in_ctl = 0; in_rd_addr = 0; in_rd_we = 0; in_is_load = 0;
    exm_rd_addr = 0; exm_rd_we = 0; exm_is_load = 0; exm_result = 0;
    mwb_rd_addr = 0; mwb_rd_we = 0; mwb_result = 0; out_ready = 0;
  endtask

  task automatic set_entry(input logic [4:0] r1, input logic [31:0] v1, input logic [4:0] r2,
                           input logic [31:0] v2, input logic [31:0] imm, input logic upc,
                           input logic uimm);
    in_rs1_addr = r1; in_rs1_data = v1; in_rs2_addr = r2; in_rs2_data = v2;
    in_imm = imm; in_use_pc = upc; in_use_imm = uimm;
    in_pc = 32'h400; in_ctl = 4'h0; in_rd_addr = 5'd3; in_rd_we = 1'b1; in_is_load = 1'b0;
  endtask

  task automatic capture();
    in_valid = 1;
    tick();
    in_valid = 0;
  endtask

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
    logic        use_pc, use_imm, we, ld;
    logic [3:0]  ctl;
    logic [31:0] ea, eb, esd;
  } vec_t;
  vec_t vecs[6];

  // Reference state: whether an instruction is held and the fields it was captured with.
  typedef struct {
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        use_pc, use_imm, we, ld;
    logic [3:0]  ctl;
  } ent_t;
  bit   m_full;
  ent_t m;

  function automatic logic [31:0] src_val(input logic [4:0] ra, input logic [31:0] held);
    if (!FWD) return held;
    if (ra == 0) return 32'h0;
    if (exm_rd_we && exm_rd_addr == ra && !exm_is_load) return exm_result;
    if (mwb_rd_we && mwb_rd_addr == ra) return mwb_result;
    return held;
  endfunction

  // Registers whose up-to-date value cannot be supplied this cycle.
  function automatic logic [31:0] busy_regs();
    logic [31:0] b = 0;
    if (FWD) begin
      if (exm_rd_we && exm_is_load) b[exm_rd_addr] = 1'b1;
    end else begin
      if (exm_rd_we) b[exm_rd_addr] = 1'b1;
      if (mwb_rd_we) b[mwb_rd_addr] = 1'b1;
    end
    b[0] = 1'b0;
    return b;
  endfunction

  initial begin
    vecs[0] = '{rs1:1,  rs2:2,  rd:3,  d1:32'd5,         d2:32'd7,         imm:32'h0,         pc:32'h100,
                use_pc:0, use_imm:0, we:1, ld:0, ctl:4'h0, ea:32'd5,         eb:32'd7,         esd:32'd7};
    vecs[1] = '{rs1:1,  rs2:2,  rd:3,  d1:32'd5,         d2:32'd7,         imm:32'h14,        pc:32'h104,
                use_pc:1, use_imm:1, we:1, ld:0, ctl:4'h0, ea:32'h104,       eb:32'h14,        esd:32'd7};
    vecs[2] = '{rs1:8,  rs2:0,  rd:9,  d1:32'hFFFF_FFFF, d2:32'h0,         imm:32'hFFFF_FFF0, pc:32'h108,
                use_pc:0, use_imm:1, we:1, ld:1, ctl:4'h8, ea:32'hFFFF_FFFF, eb:32'hFFFF_FFF0, esd:32'h0};
    vecs[3] = '{rs1:31, rs2:30, rd:31, d1:32'h8000_0000, d2:32'h7FFF_FFFF, imm:32'h0,         pc:32'h10C,
                use_pc:0, use_imm:0, we:0, ld:0, ctl:4'hF, ea:32'h8000_0000, eb:32'h7FFF_FFFF, esd:32'h7FFF_FFFF};
    vecs[4] = '{rs1:0,  rs2:12, rd:0,  d1:32'h0,         d2:32'hCAFE,      imm:32'h800,       pc:32'h200,
                use_pc:0, use_imm:1, we:0, ld:0, ctl:4'h2, ea:32'h0,         eb:32'h800,       esd:32'hCAFE};
    vecs[5] = '{rs1:3,  rs2:4,  rd:7,  d1:32'h33,        d2:32'h44,        imm:32'h0,         pc:32'hFFFF_FFFC,
                use_pc:1, use_imm:0, we:1, ld:0, ctl:4'h1, ea:32'hFFFF_FFFC, eb:32'h44,        esd:32'h44};

    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset in_ready", 32'(in_ready), 32'h1);
    chk("reset out_a", out_a, 32'h0);
    chk("reset out_b", out_b, 32'h0);
    chk("reset out_store_data", out_store_data, 32'h0);
    chk("reset out_ctl", 32'(out_ctl), 32'h0);
    chk("reset out_rd_we", 32'(out_rd_we), 32'h0);
    chk("reset out_is_load", 32'(out_is_load), 32'h0);
    chk("reset out_pc", out_pc, 32'h0);

    foreach (vecs[i]) begin
      in_rs1_addr = vecs[i].rs1; in_rs2_addr = vecs[i].rs2; in_rd_addr = vecs[i].rd;
      in_rs1_data = vecs[i].d1;  in_rs2_data = vecs[i].d2;  in_imm = vecs[i].imm;
      in_pc = vecs[i].pc; in_use_pc = vecs[i].use_pc; in_use_imm = vecs[i].use_imm;
      in_rd_we = vecs[i].we; in_is_load = vecs[i].ld; in_ctl = vecs[i].ctl;
      out_ready = 0;
      capture();
      #1;
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'h1);
      chk($sformatf("vec%0d out_a", i), out_a, vecs[i].ea);
      chk($sformatf("vec%0d out_b", i), out_b, vecs[i].eb);
      chk($sformatf("vec%0d out_store_data", i), out_store_data, vecs[i].esd);
      chk($sformatf("vec%0d out_ctl", i), 32'(out_ctl), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d out_rd_addr", i), 32'(out_rd_addr), 32'(vecs[i].rd));
      chk($sformatf("vec%0d out_rd_we", i), 32'(out_rd_we), 32'(vecs[i].we));
      chk($sformatf("vec%0d out_is_load", i), 32'(out_is_load), 32'(vecs[i].ld));
      chk($sformatf("vec%0d out_pc", i), out_pc, vecs[i].pc);
      out_ready = 1;
      tick();
      out_ready = 0;
      #1;
      chk($sformatf("vec%0d drained", i), 32'(out_valid), 32'h0);
    end

    // Back-to-back ADD x3 = x1 + x2 with a ready sink: no bubbles.
    set_entry(5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 1'b0, 1'b0);
    in_valid = 1; out_ready = 1;
    #1;
    chk("b2b in_ready first", 32'(in_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk("b2b out_valid", 32'(out_valid), 32'h1);
      chk("b2b out_a", out_a, 32'd5);
      chk("b2b out_b", out_b, 32'd7);
      chk("b2b in_ready", 32'(in_ready), 32'h1);
    end
    in_valid = 0;
    tick();
    out_ready = 0;

    // EX/MEM and MEM/WB both write x4.
    set_entry(5'd4, 32'd1, 5'd0, 32'd0, 32'h0, 1'b0, 1'b1);
    capture();
    exm_rd_we = 1; exm_rd_addr = 5'd4; exm_is_load = 0; exm_result = 32'h10;
    mwb_rd_we = 1; mwb_rd_addr = 5'd4; mwb_result = 32'h20;
    #1;
`ifdef ID_EX_FWD_EN
    chk("fwd prio out_valid", 32'(out_valid), 32'h1);
    chk("fwd prio out_a", out_a, 32'h10);
`else
    chk("nofwd exm stall out_valid", 32'(out_valid), 32'h0);
    chk("nofwd exm stall in_ready", 32'(in_ready), 32'h0);
`endif
    tick();
    exm_rd_we = 0; mwb_rd_we = 0;
    #1;
    chk("x4 after exm idle out_valid", 32'(out_valid), 32'h1);
    chk("x4 after exm idle out_a", out_a, 32'h20);
    out_ready = 1;
    tick();
    out_ready = 0;

    // Load-use on rs2 (x5).
    set_entry(5'd0, 32'd0, 5'd5, 32'd0, 32'h0, 1'b0, 1'b0);
    capture();
    exm_rd_we = 1; exm_rd_addr = 5'd5; exm_is_load = 1; exm_result = 32'h1234;
    out_ready = 1;
    #1;
    chk("load-use out_valid", 32'(out_valid), 32'h0);
    chk("load-use in_ready", 32'(in_ready), 32'h0);
    tick();
    exm_rd_we = 0; exm_is_load = 0;
    mwb_rd_we = 1; mwb_rd_addr = 5'd5; mwb_result = 32'hDEAD;
    #1;
`ifndef ID_EX_FWD_EN
    chk("nofwd wb stall out_valid", 32'(out_valid), 32'h0);
    chk("nofwd wb stall in_ready", 32'(in_ready), 32'h0);
    tick();
    mwb_rd_we = 0;
    #1;
`endif
    chk("load release out_valid", 32'(out_valid), 32'h1);
    chk("load release out_b", out_b, 32'hDEAD);
    chk("load release store_data", out_store_data, 32'hDEAD);
    mwb_rd_we = 0;
    tick();
    out_ready = 0;
    #1;
    chk("load entry drained", 32'(out_valid), 32'h0);

    // Value retires while the sink stalls; must survive after MEM/WB moves on.
    set_entry(5'd6, 32'd0, 5'd0, 32'd0, 32'd3, 1'b0, 1'b1);
    capture();
    mwb_rd_we = 1; mwb_rd_addr = 5'd6; mwb_result = 32'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
`ifdef ID_EX_FWD_EN
      chk("stall wb out_valid", 32'(out_valid), 32'h1);
      chk("stall wb out_a", out_a, 32'd9);
`else
      chk("stall wb out_valid", 32'(out_valid), 32'h0);
`endif
      tick();
    end
    mwb_rd_we = 0; mwb_rd_addr = 5'd7; mwb_result = 32'h77;
    out_ready = 1;
    #1;
    chk("refresh release out_valid", 32'(out_valid), 32'h1);
    chk("refresh release out_a", out_a, 32'd9);
    chk("refresh release out_b", out_b, 32'd3);
    tick();
    out_ready = 0;

    // Flush beats a simultaneous accept.
    set_entry(5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 1'b0, 1'b0);
    capture();
    in_valid = 1; flush = 1; out_ready = 1;
    #1;
    chk("flush cycle in_ready", 32'(in_ready), 32'h1);
    tick();
    flush = 0; in_valid = 0;
    #1;
    chk("after flush out_valid", 32'(out_valid), 32'h0);
    chk("after flush in_ready", 32'(in_ready), 32'h1);
    out_ready = 0;

    // Writes to x0 never forward or stall.
    set_entry(5'd0, 32'd0, 5'd0, 32'd0, 32'h0, 1'b0, 1'b0);
    capture();
    exm_rd_we = 1; exm_rd_addr = 5'd0; exm_is_load = 0; exm_result = 32'hFF;
    mwb_rd_we = 1; mwb_rd_addr = 5'd0; mwb_result = 32'hEE;
    #1;
    chk("x0 out_valid", 32'(out_valid), 32'h1);
    chk("x0 out_a", out_a, 32'h0);
    chk("x0 out_b", out_b, 32'h0);
    out_ready = 1;
    tick();
    idle_inputs();

    // Randomized traffic against the reference.
    rst = 1;
    tick();
    rst = 0;
    m_full = 0;
    m = '{default: '0};
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic [31:0] busy;
      logic        e_valid, e_ready, fire_in, fire_out;
      in_valid    = 1'($urandom_range(0, 1));
      flush       = ($urandom_range(0, 15) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      in_rs1_addr = 5'($urandom_range(0, 3));
      in_rs2_addr = 5'($urandom_range(0, 3));
      in_rs1_data = (in_rs1_addr == 0) ? 32'h0 : $urandom;
      in_rs2_data = (in_rs2_addr == 0) ? 32'h0 : $urandom;
      in_imm      = $urandom;
      in_pc       = $urandom;
      in_use_pc   = 1'($urandom_range(0, 1));
      in_use_imm  = 1'($urandom_range(0, 1));
      in_ctl      = 4'($urandom_range(0, 15));
      in_rd_addr  = 5'($urandom_range(0, 3));
      in_rd_we    = 1'($urandom_range(0, 1));
      in_is_load  = 1'($urandom_range(0, 1));
      exm_rd_we   = ($urandom_range(0, 2) == 0);
      exm_rd_addr = 5'($urandom_range(0, 3));
      exm_is_load = 1'($urandom_range(0, 1));
      exm_result  = $urandom;
      mwb_rd_we   = ($urandom_range(0, 2) == 0);
      mwb_rd_addr = 5'($urandom_range(0, 3));
      mwb_result  = $urandom;
      #1;
      busy     = busy_regs();
      e_valid  = m_full && !((!m.use_pc && busy[m.rs1]) || busy[m.rs2]);
      e_ready  = !m_full || (e_valid && out_ready);
      fire_in  = in_valid && e_ready;
      fire_out = e_valid && out_ready;
      chk("rnd out_valid", 32'(out_valid), 32'(e_valid));
      chk("rnd in_ready", 32'(in_ready), 32'(e_ready));
      if (m_full) begin
        chk("rnd out_a", out_a, m.use_pc ? m.pc : src_val(m.rs1, m.d1));
        chk("rnd out_b", out_b, m.use_imm ? m.imm : src_val(m.rs2, m.d2));
        chk("rnd out_store_data", out_store_data, src_val(m.rs2, m.d2));
        chk("rnd out_ctl", 32'(out_ctl), 32'(m.ctl));
        chk("rnd out_rd_addr", 32'(out_rd_addr), 32'(m.rd));
        chk("rnd out_rd_we", 32'(out_rd_we), 32'(m.we));
        chk("rnd out_is_load", 32'(out_is_load), 32'(m.ld));
        chk("rnd out_pc", out_pc, m.pc);
      end
      if (flush) begin
        m_full = 0;
      end else if (fire_in) begin
        m_full = 1;
        m = '{pc: in_pc, d1: in_rs1_data, d2: in_rs2_data, imm: in_imm, rs1: in_rs1_addr,
              rs2: in_rs2_addr, rd: in_rd_addr, use_pc: in_use_pc, use_imm: in_use_imm,
              we: in_rd_we, ld: in_is_load, ctl: in_ctl};
      end else if (fire_out) begin
        m_full = 0;
      end else if (m_full && mwb_rd_we && mwb_rd_addr != 0) begin
        if (m.rs1 == mwb_rd_addr) m.d1 = mwb_result;
        if (m.rs2 == mwb_rd_addr) m.d2 = mwb_result;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Single-entry ID/EX pipeline stage of the RV32I core, sitting directly upstream of the ALU.
- Captures a decoded instruction from decode and selects the ALU operands: rs1 or PC for `a`, rs2 or immediate for `b`.
- Resolves RAW hazards using EX/MEM and MEM/WB forwarding plus a load-use interlock.
- Drives the ALU inputs `a`, `b` and `ctl` through a valid/ready handshake.

Parameters:
XLEN, 32, data/address word width (matches WORD_WIDTH)
CTL_W, 4, ALU control width (matches ALU_CTL_WIDTH)
RA_W, 5, register address width

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
flush  input  1  kill held entry (branch/trap redirect)
in_valid  input  1  decode offers an instruction
in_ready  output  1  stage can accept
in_pc  input  XLEN  instruction PC
in_rs1_addr, in_rs2_addr  input  RA_W  source registers
in_rs1_data, in_rs2_data  input  XLEN  register-file read data
in_imm  input  XLEN  sign-extended immediate
in_use_pc  input  1  a = PC instead of rs1
in_use_imm  input  1  b = imm instead of rs2
in_ctl  input  CTL_W  ALU operation code
in_rd_addr  input  RA_W  destination register
in_rd_we  input  1  writes rd
in_is_load  input  1  instruction is a load
exm_rd_addr  input  RA_W  EX/MEM destination
exm_rd_we  input  1  EX/MEM writes rd
exm_is_load  input  1  EX/MEM holds a load (result not yet available)
exm_result  input  XLEN  EX/MEM ALU result
mwb_rd_addr  input  RA_W  MEM/WB destination
mwb_rd_we  input  1  MEM/WB writes rd
mwb_result  input  XLEN  MEM/WB writeback value
out_valid  output  1  ALU operands valid
out_ready  input  1  downstream accepts
out_a, out_b  output  XLEN  ALU operands
out_ctl  output  CTL_W  ALU control
out_store_data  output  XLEN  forwarded rs2 value (store data)
out_rd_addr  output  RA_W  destination
out_rd_we  output  1  destination write enable
out_is_load  output  1  load flag
out_pc  output  XLEN  held PC

Behaviour:
- State: `full` bit plus held registers for every in_* field except in_valid.
- Reset: `full` = 0 and all held registers = 0. Consequently out_valid = 0, out_a = out_b = out_store_data = 0, out_ctl = 0, out_rd_we = 0, out_is_load = 0, out_pc = 0.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !full | out_fire. Zero-bubble throughput: accept and drain in the same cycle.
- Capture on in_fire: held registers load at the next edge and `full` = 1. Otherwise out_fire sets `full` = 0.
- Flush:
  - Synchronous; has priority over everything.
  - Next cycle `full` = 0.
  - An in_fire in the same cycle is discarded.
  - Held data is unchanged (don't-care).
- Forwarded rsN value, per source, combinational from held state:
  - rsN == 0 -> 0.
  - Else exm_rd_we & exm_rd_addr == rsN & !exm_is_load -> exm_result.
  - Else mwb_rd_we & mwb_rd_addr == rsN -> mwb_result.
  - Else held rsN data.
  - EX/MEM always beats MEM/WB.
- Operand selection:
  - out_a = use_pc ? pc : rs1 forwarded value.
  - out_b = use_imm ? imm : rs2 forwarded value.
  - out_store_data = rs2 forwarded value.
- Data refresh: each cycle `full` is held and not draining, if mwb_rd_we & mwb_rd_addr == held rsN != 0, the held rsN data is overwritten with mwb_result. This prevents losing values that retire while the stage stalls.
- Load-use interlock: hazard = full & exm_rd_we & exm_is_load & exm_rd_addr != 0 & ((!use_pc & exm_rd_addr == rs1) | exm_rd_addr == rs2).
  - rs2 is checked even when use_imm is set, because it is needed for store data.
- out_valid = full & !hazard. While hazard, the entry holds and in_ready = 0.
- Latency: 1 cycle from in_fire to out_valid when there is no hazard.

Optional Feature:
ID_EX_FWD_EN
- Defined: forwarding exactly as above.
- Undefined:
  - No forwarding paths; operands come from held data only, with the MEM/WB data refresh still active.
  - Hazard becomes any full-entry match of a used rs (non-zero) against exm_rd_addr (exm_rd_we) or mwb_rd_addr (mwb_rd_we), regardless of is_load.
  - Stage stalls until the producer has written back.

Test Plan:
- Reset then idle -> out_valid = 0, in_ready = 1, out_a = out_b = 0.
- Back-to-back ADD x3 = x1 + x2 (x1 = 5, x2 = 7) with out_ready = 1 -> out_valid each cycle, out_a = 5, out_b = 7, in_ready never drops.
- Held rs1 = x4, rs1_data = 1, exm writes x4 = 0x10 and mwb writes x4 = 0x20 in the same cycle -> out_a = 0x10. Next cycle, exm idle -> out_a = 0x20.
- exm_is_load to x5, held rs2 = x5 -> out_valid = 0 and in_ready = 0 for 1 cycle. Load moves to mwb with value 0xDEAD -> out_valid = 1, out_b = 0xDEAD.
- out_ready = 0 for 3 cycles while mwb writes x6 = 9 and held rs1 = x6; mwb then moves on -> out_a stays 9 on release.
- flush asserted with in_valid = 1 and full -> next cycle out_valid = 0. rd = x0 forwarding check: exm writes x0 = 0xFF, rs1 = x0 -> out_a = 0.
